// File: rtl/dkong_input_ctrl.sv
// Player/coin input front-end: synchronise, debounce, latch coin, present IN-port bytes.
// Define DKONG_INPUT_DEBOUNCE_EN to build the per-bit debouncers; otherwise stable = synchroniser output.
module dkong_input_ctrl #(
    parameter int NUM_PLAYERS      = 2,
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int COIN_HOLD_CYCLES = 64
) (
    input  logic                     masterclk,
    input  logic                     rst_n,
    input  logic [5*NUM_PLAYERS-1:0] btn_raw,
    input  logic [NUM_PLAYERS-1:0]   start_raw,
    input  logic                     coin_raw,
    input  logic [2:0]               rd_sel,
    input  logic                     rd_stb,
    output logic [7:0]               rd_data,
    output logic                     coin_pending
);

    // Bit layout of every switch vector: {coin, start[N-1:0], btn[5N-1:0]}
    localparam int NBITS = 6*NUM_PLAYERS + 1;
    localparam int HW    = (COIN_HOLD_CYCLES > 1) ? $clog2(COIN_HOLD_CYCLES) : 1;

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4 || DEBOUNCE_CYCLES < 2 ||
        DEBOUNCE_CYCLES > 65535 || COIN_HOLD_CYCLES < 1 || COIN_HOLD_CYCLES > 65535) begin : g_bad_params
        $error("dkong_input_ctrl: illegal parameter value");
    end

    logic [NBITS-1:0] raw_all;
    logic [NBITS-1:0] sync_q1;
    logic [NBITS-1:0] sync_q2;
    logic [NBITS-1:0] stable;

    assign raw_all = {coin_raw, start_raw, btn_raw};

    always_ff @(posedge masterclk) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_all;
            sync_q2 <= sync_q1;
        end
    end

`ifdef DKONG_INPUT_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    for (genvar i = 0; i < NBITS; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          stb;

        // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge masterclk) begin
            if (!rst_n) begin
                cnt <= '0;
                stb <= 1'b0;
            end else if (sync_q2[i] == stb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stb <= ~stb;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = stb;
    end
`else
    assign stable = sync_q2;
`endif

    logic          coin_stable;
    logic          coin_prev;
    logic          coin_rise;
    logic          rd_clear;
    logic [HW-1:0] hold_cnt;

    assign coin_stable = stable[NBITS-1];
    assign coin_rise   = coin_stable & ~coin_prev;
    assign rd_clear    = rd_stb && (rd_sel == 3'd4) && (hold_cnt == '0);

    // A new coin edge always wins over a simultaneous clearing read
    always_ff @(posedge masterclk) begin
        if (!rst_n) begin
            coin_prev    <= 1'b0;
            coin_pending <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            coin_prev <= coin_stable;
            if (coin_rise) begin
                coin_pending <= 1'b1;
                hold_cnt     <= HW'(COIN_HOLD_CYCLES - 1);
            end else begin
                if (hold_cnt != '0)
                    hold_cnt <= hold_cnt - 1'b1;
                if (rd_clear)
                    coin_pending <= 1'b0;
            end
        end
    end

    logic [3:0] start_ext;
    logic [7:0] rd_next;

    assign start_ext = 4'(stable[6*NUM_PLAYERS-1:5*NUM_PLAYERS]);

    always_comb begin
        rd_next = 8'h00;
        if (rd_sel == 3'd4) begin
            rd_next = {coin_pending, 3'b000, start_ext};
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (rd_sel == 3'(p))
                    rd_next = {3'b000, stable[5*p +: 5]};
            end
        end
    end

    always_ff @(posedge masterclk) begin
        if (!rst_n)
            rd_data <= 8'h00;
        else
            rd_data <= rd_next;
    end

endmodule

// File: tb/tb_dkong_input_ctrl.sv
// Directed self-checking bench for dkong_input_ctrl (NUM_PLAYERS=2, D=16, hold=64).
module tb_dkong_input_ctrl;

    localparam int NP   = 2;
    localparam int DEB  = 16;
    localparam int HOLD = 64;
`ifdef DKONG_INPUT_DEBOUNCE_EN
    localparam int LAT = DEB;
`else
    localparam int LAT = 0;
`endif

    logic          masterclk = 1'b0;
    logic          rst_n     = 1'b0;
    logic [5*NP-1:0] btn_raw = '0;
    logic [NP-1:0] start_raw = '0;
    logic          coin_raw  = 1'b0;
    logic [2:0]    rd_sel    = 3'd0;
    logic          rd_stb    = 1'b0;
    logic [7:0]    rd_data;
    logic          coin_pending;

    int vectors     = 0;
    int miscompares = 0;

    dkong_input_ctrl #(
        .NUM_PLAYERS      (NP),
        .DEBOUNCE_CYCLES  (DEB),
        .COIN_HOLD_CYCLES (HOLD)
    ) dut (
        .masterclk    (masterclk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .start_raw    (start_raw),
        .coin_raw     (coin_raw),
        .rd_sel       (rd_sel),
        .rd_stb       (rd_stb),
        .rd_data      (rd_data),
        .coin_pending (coin_pending)
    );

    always #5 masterclk = ~masterclk;

    // Advance whole clocks; inputs are driven and outputs sampled 1 ns after each edge
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge masterclk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %02h, expected %02h", tag, observed, expected);
        end
    endtask

    logic [2:0] bad_sels [5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

    initial begin
        // Reset state
        applyStimulus(2);
        checkOutput("reset rd_data", rd_data, 8'h00);
        checkOutput("reset coin_pending", {7'b0, coin_pending}, 8'h00);
        rst_n = 1'b1;
        applyStimulus(2);

        // Debounce pass: p1 right, first visible LAT+2 clocks after capture
        rd_sel     = 3'd0;
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            applyStimulus(1);
            checkOutput("debounce pass", rd_data, (i == LAT + 3) ? 8'h01 : 8'h00);
        end
        btn_raw[0] = 1'b0;
        applyStimulus(LAT + 4);
        checkOutput("debounce release", rd_data, 8'h00);

        // Glitch on p2 b1
        rd_sel = 3'd1;
`ifdef DKONG_INPUT_DEBOUNCE_EN
        btn_raw[9] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1);
            checkOutput("glitch high", rd_data, 8'h00);
        end
        btn_raw[9] = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            applyStimulus(1);
            checkOutput("glitch after", rd_data, 8'h00);
        end
`else
        applyStimulus(1);
        btn_raw[9] = 1'b1;
        applyStimulus(1);
        btn_raw[9] = 1'b0;
        applyStimulus(2);
        checkOutput("raw pulse visible", rd_data, 8'h10);
        applyStimulus(1);
        checkOutput("raw pulse gone", rd_data, 8'h00);
`endif

        // Coin hold: early read ignored, late read clears
        rd_sel   = 3'd4;
        coin_raw = 1'b1;
        applyStimulus(LAT + 2);
        checkOutput("coin before rise", {7'b0, coin_pending}, 8'h00);
        applyStimulus(1);
        checkOutput("coin rise", {7'b0, coin_pending}, 8'h01);
        applyStimulus(9);
        rd_stb = 1'b1;
        applyStimulus(1);
        rd_stb = 1'b0;
        checkOutput("early read data", rd_data, 8'h80);
        checkOutput("early read kept", {7'b0, coin_pending}, 8'h01);
        applyStimulus(59);
        rd_stb = 1'b1;
        applyStimulus(1);
        rd_stb = 1'b0;
        checkOutput("late read cleared", {7'b0, coin_pending}, 8'h00);
        checkOutput("late read data", rd_data, 8'h80);
        applyStimulus(1);
        checkOutput("bit7 after clear", rd_data, 8'h00);

        // Set wins over a simultaneous qualifying clear
        coin_raw = 1'b0;
        applyStimulus(LAT + 4);
        coin_raw = 1'b1;
        applyStimulus(LAT + 3);
        checkOutput("second coin rise", {7'b0, coin_pending}, 8'h01);
        coin_raw = 1'b0;
        applyStimulus(LAT + HOLD + 4);
        checkOutput("pending without read", {7'b0, coin_pending}, 8'h01);
        coin_raw = 1'b1;
        applyStimulus(LAT + 2);
        rd_stb = 1'b1;
        applyStimulus(1);
        checkOutput("set wins", {7'b0, coin_pending}, 8'h01);
        applyStimulus(1);
        rd_stb = 1'b0;
        checkOutput("hold restarted", {7'b0, coin_pending}, 8'h01);
        coin_raw = 1'b0;
        applyStimulus(LAT + HOLD + 4);
        rd_stb = 1'b1;
        applyStimulus(1);
        rd_stb = 1'b0;
        checkOutput("cleanup clear", {7'b0, coin_pending}, 8'h00);

        // Absent player and illegal selects with every switch held
        btn_raw   = '1;
        start_raw = '1;
        applyStimulus(LAT + 4);
        for (int i = 0; i < 5; i++) begin
            rd_sel = bad_sels[i];
            applyStimulus(1);
            checkOutput("empty select", rd_data, 8'h00);
        end
        rd_sel = 3'd0;
        applyStimulus(1);
        checkOutput("p1 all held", rd_data, 8'h1F);
        rd_sel = 3'd1;
        applyStimulus(1);
        checkOutput("p2 all held", rd_data, 8'h1F);
        rd_sel = 3'd4;
        applyStimulus(1);
        checkOutput("system starts", rd_data, 8'h03);

        // Reset mid-operation
        btn_raw   = '0;
        start_raw = '0;
        applyStimulus(LAT + 4);
        coin_raw = 1'b1;
        applyStimulus(LAT + 3);
        checkOutput("pre-reset coin", {7'b0, coin_pending}, 8'h01);
        coin_raw   = 1'b0;
        rd_sel     = 3'd0;
        btn_raw[0] = 1'b1;
        applyStimulus(13);
        rst_n = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        checkOutput("reset rd_data mid", rd_data, 8'h00);
        checkOutput("reset coin mid", {7'b0, coin_pending}, 8'h00);
        for (int i = 1; i <= LAT + 3; i++) begin
            applyStimulus(1);
            checkOutput("re-debounce", rd_data, (i == LAT + 3) ? 8'h01 : 8'h00);
        end
        checkOutput("coin after reset", {7'b0, coin_pending}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
